// File: rtl/bin2bcd_pkg.sv
// Shared widths, FSM state encoding and the dash-position helper for the
// sequential binary-to-BCD converter.
package bin2bcd_pkg;
  localparam int DATA_W = 16;
  localparam int N_DIG  = 5;
  localparam int BCD_W  = 4 * N_DIG;
  localparam int DASH_W = N_DIG + 1;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] ITER_LAST = 4'd15;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  // '-' goes one display left of the most significant nonzero digit.
  function automatic logic [DASH_W-1:0] dash_of(input logic [BCD_W-1:0] bcd,
                                                input logic             neg);
    logic [DASH_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 0; i < N_DIG; i++)
      if (bcd[4*i +: 4] != 4'd0) k = i + 1;
    if (neg) d = {{(DASH_W-1){1'b0}}, 1'b1} << k;
    return d;
  endfunction
endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter with display dash vector.
// Define BIN2BCD_SIGNED_EN to treat value as two's complement (neg/dash live).
module bin2bcd_seq
  import bin2bcd_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] value_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o,
  output logic              neg_o,
  output logic [DASH_W-1:0] dash_o
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  val_q, val_d;
  logic [DATA_W-1:0]  mag_q, mag_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic               sgn_q, sgn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic [DASH_W-1:0]  dash_q, dash_d;

  logic [BCD_W-1:0]   acc_fix;
  logic [BCD_W-1:0]   acc_sh;
  logic               load_sgn;
  logic [DATA_W-1:0]  load_mag;

  for (genvar g = 0; g < N_DIG; g++) begin : g_dig
    bcd_add3 u_add3 (.d_i(acc_q[4*g +: 4]), .q_o(acc_fix[4*g +: 4]));
  end

  assign acc_sh = {acc_fix[BCD_W-2:0], mag_q[DATA_W-1]};

`ifdef BIN2BCD_SIGNED_EN
  // Two's-complement negate; 0x8000 maps onto itself, which reads as 32768 unsigned.
  assign load_sgn = val_q[DATA_W-1];
  assign load_mag = load_sgn ? (~val_q) + DATA_W'(1) : val_q;
`else
  assign load_sgn = 1'b0;
  assign load_mag = val_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    sgn_d   = sgn_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    dash_d  = dash_q;
    case (state_q)
      IDLE: if (start_i) begin
        val_d   = value_i;
        state_d = LOAD;
      end
      LOAD: begin
        sgn_d   = load_sgn;
        mag_d   = load_mag;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = acc_sh;
        mag_d = {mag_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        // Result registers load on the way into DONE so they are visible with done.
        if (cnt_q == ITER_LAST) begin
          cnt_d   = '0;
          bcd_d   = acc_sh;
          neg_d   = sgn_q;
          dash_d  = dash_of(acc_sh, sgn_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      dash_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      dash_q  <= dash_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign neg_o  = neg_q;
  assign dash_o = dash_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: fixed vectors, random values against an
// arithmetic model, and multi-cycle corner sequences (ignored start, reset, back-to-back).
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  logic        clk, rst, start;
  logic [15:0] value;
  logic        busy, done, neg;
  logic [19:0] bcd;
  logic [5:0]  dash;

  int checks = 0;
  int errors = 0;

  logic [19:0] prev_bcd;
  logic        prev_neg;
  logic [5:0]  prev_dash;

  bin2bcd_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .value_i(value),
    .busy_o(busy), .done_o(done), .bcd_o(bcd), .neg_o(neg), .dash_o(dash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] v;
    logic [19:0] bcd;
    logic        n;
    logic [5:0]  d;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal digits via division; sign per build.
  task automatic model(input logic [15:0] v, output logic [19:0] b, output logic n,
                       output logic [5:0] d);
    int m, p, k;
`ifdef BIN2BCD_SIGNED_EN
    n = v[15];
    m = n ? 65536 - int'(v) : int'(v);
`else
    n = 1'b0;
    m = int'(v);
`endif
    b = '0;
    p = 1;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'((m / p) % 10);
      if (((m / p) % 10) != 0) k = i + 1;
      p = p * 10;
    end
    d = n ? 6'(1 << k) : 6'd0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full conversion; also checks latency, busy length and output hold.
  task automatic verify(input string name, input logic [15:0] v, input logic [19:0] eb,
                        input logic en, input logic [5:0] ed);
    int lat, busy_n;
    logic stable;
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    value = 16'($urandom);
    lat = 1;
    busy_n = 0;
    stable = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (bcd !== prev_bcd || neg !== prev_neg || dash !== prev_dash) stable = 1'b0;
      tick();
      lat++;
    end
    chk({name, " latency"}, lat, 18);
    chk({name, " busy_cycles"}, busy_n, 17);
    chk({name, " hold"}, {31'd0, stable}, 1);
    chk({name, " bcd"}, bcd, eb);
    chk({name, " neg"}, neg, en);
    chk({name, " dash"}, dash, ed);
    chk({name, " busy_in_done"}, busy, 0);
    prev_bcd = eb;
    prev_neg = en;
    prev_dash = ed;
    tick();
  endtask

  initial begin
    vec_t tbl[8];
    logic [19:0] mb;
    logic        mn;
    logic [5:0]  md;
    int ndone, first_at, second_at;
    logic [19:0] bcd_at;

    tbl[0] = '{16'd0,     20'h00000, 1'b0, 6'd0};
    tbl[1] = '{16'd12345, 20'h12345, 1'b0, 6'd0};
    tbl[2] = '{16'd1,     20'h00001, 1'b0, 6'd0};
    tbl[3] = '{16'd10,    20'h00010, 1'b0, 6'd0};
    tbl[4] = '{16'd9999,  20'h09999, 1'b0, 6'd0};
`ifdef BIN2BCD_SIGNED_EN
    tbl[5] = '{16'hFFFF,  20'h00001, 1'b1, 6'b000010};
    tbl[6] = '{16'h8000,  20'h32768, 1'b1, 6'b100000};
    tbl[7] = '{16'hFF9C,  20'h00100, 1'b1, 6'b001000};
`else
    tbl[5] = '{16'hFFFF,  20'h65535, 1'b0, 6'd0};
    tbl[6] = '{16'h8000,  20'h32768, 1'b0, 6'd0};
    tbl[7] = '{16'hFF9C,  20'h65436, 1'b0, 6'd0};
`endif

    rst = 1'b1;
    start = 1'b0;
    value = '0;
    prev_bcd = '0;
    prev_neg = 1'b0;
    prev_dash = '0;
    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bcd", bcd, 0);
    chk("reset neg", neg, 0);
    chk("reset dash", dash, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      verify($sformatf("vec%0d", i), tbl[i].v, tbl[i].bcd, tbl[i].n, tbl[i].d);

    // Result holds while idle.
    verify("hold12345", 16'd12345, 20'h12345, 1'b0, 6'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("idle hold bcd", bcd, 20'h12345);
    chk("idle done low", done, 0);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] rv;
      rv = 16'($urandom);
      model(rv, mb, mn, md);
      verify($sformatf("rand%0d_%0h", i, rv), rv, mb, mn, md);
    end

    // Second start during conversion is dropped.
    start = 1'b1;
    value = 16'd99;
    tick();
    start = 1'b0;
    ndone = 0;
    first_at = 0;
    bcd_at = '0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 5) begin start = 1'b1; value = 16'd7; end
      if (n == 6) start = 1'b0;
      if (done) begin ndone++; first_at = n; bcd_at = bcd; end
      tick();
    end
    chk("ignored start done count", ndone, 1);
    chk("ignored start done cycle", first_at, 18);
    chk("ignored start bcd", bcd_at, 20'h00099);
    prev_bcd = 20'h00099;
    prev_neg = 1'b0;
    prev_dash = '0;

    // Reset mid-SHIFT aborts with no done.
    start = 1'b1;
    value = 16'd500;
    tick();
    start = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst bcd", bcd, 0);
    chk("midrst neg", neg, 0);
    chk("midrst dash", dash, 0);
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      if (done) ndone++;
      tick();
    end
    chk("midrst no done", ndone, 0);
    prev_bcd = '0;
    prev_neg = 1'b0;
    prev_dash = '0;
    model(16'd4321, mb, mn, md);
    verify("post reset", 16'd4321, mb, mn, md);

    // Start held high: conversions 19 cycles apart.
    start = 1'b1;
    value = 16'd2024;
    tick();
    ndone = 0;
    first_at = 0;
    second_at = 0;
    bcd_at = '0;
    for (int n = 1; n <= 38; n++) begin
      if (n == 38) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) first_at = n; else second_at = n;
        bcd_at = bcd;
      end
      tick();
    end
    chk("b2b done count", ndone, 2);
    chk("b2b first", first_at, 18);
    chk("b2b second", second_at, 37);
    chk("b2b bcd", bcd_at, 20'h02024);
    chk("b2b idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
